// File: rtl/uart_cfg.sv
// Full-duplex UART: configurable width/parity/stop/oversampling, ready/valid byte ports.
// Prescalers restart at frame start; RX bits are a 3-sample majority around mid-bit.
module uart_cfg #(
    parameter int CLK_DIV    = 325,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy,
    output logic                 tx_busy
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TCK_MAX  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SMP_A    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SMP_B    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] SMP_C    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam bit HAS_PAR = (PARITY != 0);
    localparam bit ODD_PAR = (PARITY == 1);

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return ODD_PAR ? ~^d : ^d;
    endfunction

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_st_t;

    tx_st_t               tx_st, tx_st_nx;
    logic [PW-1:0]        tx_pre;
    logic [TW-1:0]        tx_tcnt;
    logic [BW-1:0]        tx_bidx;
    logic                 tx_scnt;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;
    logic                 tx_tick, tx_bit_end, tx_stop_last, tx_acc;

    assign tx_tick      = (tx_pre == PRE_MAX);
    assign tx_bit_end   = tx_tick && (tx_tcnt == TCK_MAX);
    assign tx_stop_last = (tx_st == TX_STOP) && tx_bit_end && ((STOP_BITS == 1) || tx_scnt);
    // Ready on the final STOP cycle so a waiting word starts with no idle gap.
    assign tx_ready     = (tx_st == TX_IDLE) || tx_stop_last;
    assign tx_acc       = tx_valid && tx_ready;
    assign tx_busy      = !tx_ready;

    always_comb begin
        tx_st_nx = tx_st;
        tx       = 1'b1;
        case (tx_st)
            TX_IDLE:  ;
            TX_START: begin
                tx = 1'b0;
                if (tx_bit_end) tx_st_nx = TX_DATA;
            end
            TX_DATA: begin
                tx = tx_sh[0];
                if (tx_bit_end && (tx_bidx == BIT_LAST)) tx_st_nx = HAS_PAR ? TX_PAR : TX_STOP;
            end
            TX_PAR: begin
                tx = tx_par;
                if (tx_bit_end) tx_st_nx = TX_STOP;
            end
            TX_STOP: begin
                if (tx_stop_last) tx_st_nx = TX_IDLE;
            end
            default: tx_st_nx = TX_IDLE;
        endcase
        if (tx_acc) tx_st_nx = TX_START;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st   <= TX_IDLE;
            tx_pre  <= '0;
            tx_tcnt <= '0;
            tx_bidx <= '0;
            tx_scnt <= 1'b0;
            tx_sh   <= '0;
            tx_par  <= 1'b0;
        end else begin
            tx_st <= tx_st_nx;
            if (tx_acc) begin
                tx_pre  <= '0;
                tx_tcnt <= '0;
                tx_bidx <= '0;
                tx_scnt <= 1'b0;
                tx_sh   <= tx_data;
                tx_par  <= par_of(tx_data);
            end else if (tx_st != TX_IDLE) begin
                tx_pre <= tx_tick ? '0 : tx_pre + 1'b1;
                if (tx_tick) tx_tcnt <= (tx_tcnt == TCK_MAX) ? '0 : tx_tcnt + 1'b1;
                if (tx_bit_end) begin
                    case (tx_st)
                        TX_DATA: begin
                            tx_sh   <= tx_sh >> 1;
                            tx_bidx <= tx_bidx + 1'b1;
                        end
                        TX_STOP: tx_scnt <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_st_t;

    rx_st_t               rx_st, rx_st_nx;
    logic                 rx_m, rx_s;
    logic [PW-1:0]        rx_pre;
    logic [TW-1:0]        rx_tcnt;
    logic [BW-1:0]        rx_bidx;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_smp_a, rx_smp_b, rx_perr;
    logic                 rx_tick, rx_dec, rx_maj, rx_done;

    assign rx_tick = (rx_pre == PRE_MAX);
    assign rx_dec  = rx_tick && (rx_tcnt == SMP_C);
    assign rx_maj  = (rx_smp_a & rx_smp_b) | (rx_smp_a & rx_s) | (rx_smp_b & rx_s);
    assign rx_busy = (rx_st != RX_IDLE);

    // The tick counter free-runs from the start edge; each state waits for its own
    // mid-bit decision, so successive decisions are exactly OVERSAMPLE ticks apart.
    always_comb begin
        rx_st_nx = rx_st;
        rx_done  = 1'b0;
        case (rx_st)
            RX_IDLE:  if (!rx_s) rx_st_nx = RX_START;
            RX_START: if (rx_dec) rx_st_nx = rx_maj ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_dec && (rx_bidx == BIT_LAST)) rx_st_nx = HAS_PAR ? RX_PAR : RX_STOP;
            RX_PAR:   if (rx_dec) rx_st_nx = RX_STOP;
            RX_STOP: begin
                if (rx_dec) begin
                    rx_done  = 1'b1;
                    rx_st_nx = rx_maj ? RX_IDLE : RX_WAIT;
                end
            end
            RX_WAIT:  if (rx_s) rx_st_nx = RX_IDLE;
            default:  rx_st_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            rx_st         <= RX_IDLE;
            rx_pre        <= '0;
            rx_tcnt       <= '0;
            rx_bidx       <= '0;
            rx_sh         <= '0;
            rx_smp_a      <= 1'b1;
            rx_smp_b      <= 1'b1;
            rx_perr       <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_m     <= rx;
            rx_s     <= rx_m;
            rx_st    <= rx_st_nx;
            rx_valid <= rx_done;
            if (rx_st == RX_IDLE) begin
                rx_pre  <= '0;
                rx_tcnt <= '0;
                rx_bidx <= '0;
                rx_perr <= 1'b0;
            end else begin
                rx_pre <= rx_tick ? '0 : rx_pre + 1'b1;
                if (rx_tick) rx_tcnt <= (rx_tcnt == TCK_MAX) ? '0 : rx_tcnt + 1'b1;
            end
            if (rx_tick && (rx_tcnt == SMP_A)) rx_smp_a <= rx_s;
            if (rx_tick && (rx_tcnt == SMP_B)) rx_smp_b <= rx_s;
            if (rx_dec) begin
                case (rx_st)
                    RX_DATA: begin
                        rx_sh   <= {rx_maj, rx_sh[DATA_BITS-1:1]};
                        rx_bidx <= rx_bidx + 1'b1;
                    end
                    RX_PAR:  rx_perr <= (rx_maj != par_of(rx_sh));
                    RX_STOP: begin
                        rx_data       <= rx_sh;
                        rx_parity_err <= rx_perr;
                        rx_frame_err  <= !rx_maj;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: five instances (8N1, 8E1, 8O2, 5N1, 9E1) at CLK_DIV=4, OVERSAMPLE=16.
module tb_uart_cfg;
    localparam int T = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b1;
    logic lb_e1 = 1'b0;
    logic e1_rx;
    logic [4:0]      tv = '0;
    logic [4:0][8:0] td = '0;
    logic [4:0]      trdy, txo, rxv, perr, ferr, rbusy, tbusy;
    logic [4:0][8:0] rxd;
    logic [7:0] n1_rxd, e1_rxd, o2_rxd;
    logic [4:0] d5_rxd;
    logic [8:0] d9_rxd;

    int n_chk = 0;
    int n_err = 0;
    int vcnt [5] = '{default: 0};
    logic [8:0] ld [5];
    logic       lp [5];
    logic       lf [5];

    always #5 clk = ~clk;

    assign e1_rx  = lb_e1 ? txo[1] : rx_line;
    assign rxd[0] = {1'b0, n1_rxd};
    assign rxd[1] = {1'b0, e1_rxd};
    assign rxd[2] = {1'b0, o2_rxd};
    assign rxd[3] = {4'b0, d5_rxd};
    assign rxd[4] = d9_rxd;

    uart_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .rx(rx_line), .tx(txo[0]), .tx_valid(tv[0]), .tx_ready(trdy[0]),
        .tx_data(td[0][7:0]), .rx_valid(rxv[0]), .rx_data(n1_rxd), .rx_parity_err(perr[0]),
        .rx_frame_err(ferr[0]), .rx_busy(rbusy[0]), .tx_busy(tbusy[0]));
    uart_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .rx(e1_rx), .tx(txo[1]), .tx_valid(tv[1]), .tx_ready(trdy[1]),
        .tx_data(td[1][7:0]), .rx_valid(rxv[1]), .rx_data(e1_rxd), .rx_parity_err(perr[1]),
        .rx_frame_err(ferr[1]), .rx_busy(rbusy[1]), .tx_busy(tbusy[1]));
    uart_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_o2 (
        .clk(clk), .rst(rst), .rx(txo[2]), .tx(txo[2]), .tx_valid(tv[2]), .tx_ready(trdy[2]),
        .tx_data(td[2][7:0]), .rx_valid(rxv[2]), .rx_data(o2_rxd), .rx_parity_err(perr[2]),
        .rx_frame_err(ferr[2]), .rx_busy(rbusy[2]), .tx_busy(tbusy[2]));
    uart_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_d5 (
        .clk(clk), .rst(rst), .rx(rx_line), .tx(txo[3]), .tx_valid(tv[3]), .tx_ready(trdy[3]),
        .tx_data(td[3][4:0]), .rx_valid(rxv[3]), .rx_data(d5_rxd), .rx_parity_err(perr[3]),
        .rx_frame_err(ferr[3]), .rx_busy(rbusy[3]), .tx_busy(tbusy[3]));
    uart_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) u_d9 (
        .clk(clk), .rst(rst), .rx(rx_line), .tx(txo[4]), .tx_valid(tv[4]), .tx_ready(trdy[4]),
        .tx_data(td[4]), .rx_valid(rxv[4]), .rx_data(d9_rxd), .rx_parity_err(perr[4]),
        .rx_frame_err(ferr[4]), .rx_busy(rbusy[4]), .tx_busy(tbusy[4]));

    // Record every rx_valid pulse with the word and flags it qualifies.
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rxv[i]) begin
                vcnt[i]++;
                ld[i] = rxd[i];
                lp[i] = perr[i];
                lf[i] = ferr[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Call at a negedge; returns at the first negedge where tx_ready is high again.
    task automatic send_tx(input int i, input logic [8:0] d, output int len);
        tv[i] = 1'b1;
        td[i] = d;
        @(negedge clk);
        tv[i] = 1'b0;
        len = 1;
        while (!trdy[i] && len < 3000) begin
            @(negedge clk);
            len++;
        end
    endtask

    // One bit period on rx_line; gl flips the line for one clk on the mid-bit sample.
    task automatic drive_bit(input logic v, input bit gl);
        for (int c = 0; c < T; c++) begin
            rx_line = (gl && c == 36) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic drive_frame(input logic [8:0] d, input int nb, input bit hp,
                               input logic pb, input logic sv, input bit gl);
        drive_bit(1'b0, gl);
        for (int b = 0; b < nb; b++) drive_bit(d[b], gl);
        if (hp) drive_bit(pb, gl);
        drive_bit(sv, gl);
    endtask

    initial begin
        int len;
        int c0;
        logic exp_tx;
        logic [7:0] a5;
        a5 = 8'hA5;

        cyc(4);
        rst = 1'b0;
        cyc(2);
        chk("rst_tx", txo[0], 1);
        chk("rst_rdy", trdy[0], 1);
        chk("rst_rxv", rxv[0], 0);
        chk("rst_rxd", n1_rxd, 0);
        chk("rst_perr", perr[0], 0);
        chk("rst_ferr", ferr[0], 0);
        chk("rst_rbusy", rbusy[0], 0);
        chk("rst_tbusy", tbusy[0], 0);

        // 8N1 TX bit timing, accept at cycle 0
        tv[0] = 1'b1;
        td[0] = 9'h0A5;
        @(negedge clk);
        tv[0] = 1'b0;
        for (int c = 1; c <= 640; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 64) exp_tx = 1'b0;
            else if (c <= 576) exp_tx = a5[(c - 65) / 64];
            else exp_tx = 1'b1;
            if ((c % 64) == 1 || (c % 64) == 0) chk("t1_tx", txo[0], exp_tx);
            if (c == 1 || c == 639) chk("t1_rdy_lo", trdy[0], 0);
            if (c == 640) chk("t1_rdy_hi", trdy[0], 1);
        end
        cyc(10);

        // loopback 8E1 and 8O2
        lb_e1 = 1'b1;
        c0 = vcnt[1];
        send_tx(1, 9'h05A, len);
        chk("t2_e1_len", len, 704);
        cyc(20);
        chk("t2_e1_cnt", vcnt[1] - c0, 1);
        chk("t2_e1_data", ld[1], 9'h05A);
        chk("t2_e1_perr", lp[1], 0);
        chk("t2_e1_ferr", lf[1], 0);
        lb_e1 = 1'b0;
        c0 = vcnt[2];
        send_tx(2, 9'h0FF, len);
        chk("t2_o2_len", len, 768);
        cyc(20);
        chk("t2_o2_cnt", vcnt[2] - c0, 1);
        chk("t2_o2_data", ld[2], 9'h0FF);
        chk("t2_o2_perr", lp[2], 0);
        chk("t2_o2_ferr", lf[2], 0);
        cyc(100);

        // 5-clk start glitch
        c0 = vcnt[0];
        rx_line = 1'b0;
        cyc(5);
        rx_line = 1'b1;
        chk("t3_busy_hi", rbusy[0], 1);
        cyc(100);
        chk("t3_busy_lo", rbusy[0], 0);
        chk("t3_cnt", vcnt[0] - c0, 0);
        chk("t3_perr", perr[0], 0);
        chk("t3_ferr", ferr[0], 0);
        cyc(100);

        // 8E1 frame 0x01 with wrong parity
        c0 = vcnt[1];
        drive_frame(9'h001, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        rx_line = 1'b1;
        cyc(10);
        chk("t4_cnt", vcnt[1] - c0, 1);
        chk("t4_data", ld[1], 9'h001);
        chk("t4_perr", lp[1], 1);
        chk("t4_ferr", lf[1], 0);
        cyc(800);

        // stop bit low then break, then a clean frame
        c0 = vcnt[1];
        drive_frame(9'h03C, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(200);
        chk("t5_cnt", vcnt[1] - c0, 1);
        chk("t5_data", ld[1], 9'h03C);
        chk("t5_ferr", lf[1], 1);
        chk("t5_perr", lp[1], 0);
        chk("t5_wait", rbusy[1], 1);
        rx_line = 1'b1;
        cyc(20);
        chk("t5_idle", rbusy[1], 0);
        cyc(100);
        c0 = vcnt[1];
        drive_frame(9'h011, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        rx_line = 1'b1;
        cyc(10);
        chk("t5b_cnt", vcnt[1] - c0, 1);
        chk("t5b_data", ld[1], 9'h011);
        chk("t5b_perr", lp[1], 0);
        chk("t5b_ferr", lf[1], 0);
        cyc(800);

        // majority vote rejects single-clk mid-sample glitches, 5 and 9 bit words
        c0 = vcnt[3];
        drive_frame(9'h015, 5, 1'b0, 1'b0, 1'b1, 1'b1);
        rx_line = 1'b1;
        cyc(10);
        chk("d5_cnt", vcnt[3] - c0, 1);
        chk("d5_data", ld[3], 9'h015);
        chk("d5_ferr", lf[3], 0);
        cyc(800);
        c0 = vcnt[4];
        drive_frame(9'h1A5, 9, 1'b1, 1'b1, 1'b1, 1'b1);
        rx_line = 1'b1;
        cyc(10);
        chk("d9_cnt", vcnt[4] - c0, 1);
        chk("d9_data", ld[4], 9'h1A5);
        chk("d9_perr", lp[4], 0);
        chk("d9_ferr", lf[4], 0);
        cyc(800);

        // reset mid data bit on both directions
        c0 = vcnt[0];
        rx_line = 1'b0;
        tv[0] = 1'b1;
        td[0] = 9'h000;
        @(negedge clk);
        tv[0] = 1'b0;
        cyc(150);
        chk("t6_pre_tx", txo[0], 0);
        chk("t6_pre_rdy", trdy[0], 0);
        chk("t6_pre_rbusy", rbusy[0], 1);
        rst = 1'b1;
        rx_line = 1'b1;
        @(negedge clk);
        chk("t6_tx", txo[0], 1);
        chk("t6_rdy", trdy[0], 1);
        chk("t6_rbusy", rbusy[0], 0);
        rst = 1'b0;
        cyc(100);
        chk("t6_cnt", vcnt[0] - c0, 0);
        send_tx(0, 9'h0C3, len);
        chk("t6_len", len, 640);
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
